// File: rtl/ahb_flash_rd_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ahb_flash_rd_if : AHB-Lite read slave for a wait-state flash, with a
//                   one-word read buffer and optional next-word prefetch.
// rev 1.0
// ---------------------------------------------------------------------------
module ahb_flash_rd_if #(
   parameter int AW       = 16,
   parameter int WS       = 1,
   parameter int PREFETCH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          HSEL,
   input  logic [AW-1:0] HADDR,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HSIZE,
   input  logic          HWRITE,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   output logic [AW-3:0] FLASHADDR,
   input  logic [31:0]   FLASHRDATA
);

   localparam int         FW     = AW - 2;
   localparam logic [3:0] WS_C   = 4'(WS);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BUF   = 3'd1;
   localparam logic [2:0] S_FLASH = 3'd2;
   localparam logic [2:0] S_ERR1  = 3'd3;
   localparam logic [2:0] S_ERR2  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [FW-1:0] flashaddr_q, flashaddr_d;
   logic [3:0]    age_q, age_d;
   logic [FW-1:0] cur_addr_q, cur_addr_d;
   logic [31:0]   cur_data_q, cur_data_d;
   logic          cur_valid_q, cur_valid_d;

   logic          flash_ready, flash_cmpl, phase_done;
   logic          xfer, buf_hit, rd_flash, pf_go;
   logic [FW-1:0] req_addr, pf_addr;

   // Transfer size and byte lane are irrelevant: a full word is always returned.
   logic unused_ok;
   assign unused_ok = ^{HSIZE, HADDR[1:0], HTRANS[0]};

   assign flash_ready = (age_q >= WS_C);
   assign flash_cmpl  = (state_q == S_FLASH) && flash_ready;
   assign phase_done  = (state_q == S_IDLE) || (state_q == S_BUF) ||
                        (state_q == S_ERR2) || flash_cmpl;
   assign xfer        = HSEL && HREADY && HTRANS[1] && phase_done;
   assign req_addr    = HADDR[AW-1:2];

   // Hit test uses the post-edge buffer so a word completing now already counts.
   assign buf_hit  = xfer && !HWRITE && cur_valid_d && (req_addr == cur_addr_d);
   assign rd_flash = xfer && !HWRITE && !buf_hit;
   assign pf_addr  = cur_addr_d + FW'(1);
   assign pf_go    = (PREFETCH != 0) && (state_d != S_FLASH) && cur_valid_d &&
                     (flashaddr_q != pf_addr);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end else if (phase_done) begin
         if (!xfer)       state_d = S_IDLE;
         else if (HWRITE) state_d = S_ERR1;
         else if (buf_hit) state_d = S_BUF;
         else             state_d = S_FLASH;
      end
   end

   // output logic
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = 32'h0;
      case (state_q)
         S_BUF:   HRDATA = cur_data_q;
         S_FLASH: begin
            HREADYOUT = flash_ready;
            if (flash_ready) HRDATA = FLASHRDATA;
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         S_ERR2:  HRESP = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cur_valid_d = cur_valid_q;
      cur_addr_d  = cur_addr_q;
      cur_data_d  = cur_data_q;
      if (flash_cmpl) begin
         cur_valid_d = 1'b1;
         cur_addr_d  = flashaddr_q;
         cur_data_d  = FLASHRDATA;
      end
   end

   // A demand miss wins over prefetch; any address load restarts the age.
   always_comb begin
      flashaddr_d = flashaddr_q;
      age_d       = (age_q < WS_C) ? age_q + 4'd1 : age_q;
      if (rd_flash && (req_addr != flashaddr_q)) begin
         flashaddr_d = req_addr;
         age_d       = 4'd0;
      end else if (pf_go) begin
         flashaddr_d = pf_addr;
         age_d       = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flashaddr_q <= '0;
         age_q       <= 4'd0;
         cur_addr_q  <= '0;
         cur_data_q  <= 32'h0;
         cur_valid_q <= 1'b0;
      end else begin
         flashaddr_q <= flashaddr_d;
         age_q       <= age_d;
         cur_addr_q  <= cur_addr_d;
         cur_data_q  <= cur_data_d;
         cur_valid_q <= cur_valid_d;
      end
   end

   assign FLASHADDR = flashaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_flash_rd_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ahb_flash_rd_if : directed bench with a cycle-stamp reference model.
// rev 1.0
// ---------------------------------------------------------------------------
module tb_ahb_flash_rd_if;

   localparam int AW = 16;
   localparam int N  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic        hsel_en;
   int          cur;

   logic [N-1:0] hsel, hro, hrs;
   logic [31:0]  hrd [N];
   logic [13:0]  fa  [N];
   logic [31:0]  frd [N];

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int ws_cur;
   bit pf_cur;
   bit chk_en = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [13:0] w);
      return (w == 14'h40) ? 32'h11223344 : {16'hC0DE, 2'b00, w};
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int GWS = (g == 0) ? 2 : 3;
      localparam int GPF = (g == 0) ? 0 : 1;
      logic [3:0]  fk;
      logic [13:0] flast;

      assign hsel[g] = hsel_en && (cur == g);

      ahb_flash_rd_if #(.AW(AW), .WS(GWS), .PREFETCH(GPF)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .HSEL       (hsel[g]),
         .HADDR      (haddr),
         .HTRANS     (htrans),
         .HSIZE      (hsize),
         .HWRITE     (hwrite),
         .HREADY     (hro[g]),
         .HREADYOUT  (hro[g]),
         .HRESP      (hrs[g]),
         .HRDATA     (hrd[g]),
         .FLASHADDR  (fa[g]),
         .FLASHRDATA (frd[g])
      );

      // flash: data valid on the k-th cycle after an address change iff k >= WS
      initial begin
         flast = 14'h0;
         fk    = 4'd15;
      end
      always @(posedge clk) begin
         #1;
         if (fa[g] != flast) begin
            flast = fa[g];
            fk    = 4'd0;
         end else if (fk != 4'd15) begin
            fk = fk + 4'd1;
         end
      end
      assign frd[g] = (int'(fk) >= GWS) ? mem_word(fa[g]) : 32'hFFFF_FFFF;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: flash address plus the cycle it was loaded, the read
   // buffer, and the cycle at which the current data phase becomes ready.
   logic        m_busy, m_wr, m_fl, m_bv;
   int          m_rdy, m_fat;
   logic [31:0] m_data, m_bd;
   logic [13:0] m_fa, m_ba;

   always @(posedge clk) begin
      logic        done;
      logic [13:0] a;
      cyc = cyc + 1;
      if (!rst_n) begin
         m_busy = 1'b0; m_fa = 14'h0; m_fat = cyc; m_bv = 1'b0;
         m_wr = 1'b0; m_fl = 1'b0; m_rdy = 0; m_data = 32'h0;
      end else begin
         done = !m_busy || (cyc - 1 >= m_rdy);
         if (m_busy && done && m_fl) begin
            m_bv = 1'b1; m_ba = m_fa; m_bd = mem_word(m_fa);
         end
         if (done) m_busy = 1'b0;
         a = haddr[15:2];
         if (done && hsel_en && htrans[1]) begin
            m_busy = 1'b1; m_wr = hwrite; m_fl = 1'b0;
            if (hwrite) begin
               m_rdy = cyc + 1;
            end else if (m_bv && a == m_ba) begin
               m_rdy = cyc; m_data = m_bd;
            end else begin
               m_fl = 1'b1;
               if (a != m_fa) begin m_fa = a; m_fat = cyc; end
               m_rdy = (m_fat + ws_cur > cyc) ? m_fat + ws_cur : cyc;
            end
         end
         if (pf_cur && !(m_busy && m_fl) && m_bv && m_fa != m_ba + 14'd1) begin
            m_fa = m_ba + 14'd1; m_fat = cyc;
         end
      end
   end

   always @(negedge clk) begin
      logic        e_rdy;
      logic [31:0] e_data;
      if (rst_n && chk_en) begin
         e_rdy  = m_busy ? (cyc >= m_rdy) : 1'b1;
         e_data = 32'h0;
         if (m_busy && !m_wr && e_rdy) e_data = m_fl ? mem_word(m_fa) : m_data;
         check("hreadyout", {31'h0, hro[cur]}, {31'h0, e_rdy});
         check("hresp", {31'h0, hrs[cur]}, {31'h0, m_busy && m_wr});
         check("hrdata", hrd[cur], e_data);
         check("flashaddr", {18'h0, fa[cur]}, {18'h0, m_fa});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [15:0] addr, input logic wr, output int waits,
                       output logic [31:0] data, output logic resp1, output logic respn);
      haddr = addr; hwrite = wr; htrans = 2'b10;
      @(posedge clk); #1;
      htrans = 2'b00; hwrite = 1'b0;
      waits = 0;
      @(negedge clk);
      resp1 = hrs[cur];
      while (!hro[cur] && waits < 40) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 40) check("xfer_timeout", 32'(waits), 32'd0);
      data  = hrd[cur];
      respn = hrs[cur];
      @(posedge clk); #1;
   endtask

   task automatic apply_reset(input int inst, input int ws, input bit pf);
      rst_n = 1'b0;
      cur = inst; ws_cur = ws; pf_cur = pf;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          w;
      logic [31:0] d;
      logic        r1, rn;
      hsel_en = 1'b0; htrans = 2'b00; haddr = 16'h0; hwrite = 1'b0; hsize = 3'b010;
      cur = 0; ws_cur = 2; pf_cur = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hreadyout", {31'h0, hro[0]}, 32'd1);
      check("rst_hresp", {31'h0, hrs[0]}, 32'd0);
      check("rst_hrdata", hrd[0], 32'h0);
      check("rst_flashaddr", {18'h0, fa[0]}, 32'h0);
      rst_n = 1'b1; chk_en = 1'b1; hsel_en = 1'b1;
      idle(2);

      // WS=2, no prefetch: miss then buffer hit
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      check("t1_waits", 32'(w), 32'd2);
      check("t1_data", d, 32'h11223344);
      check("t1_resp", {31'h0, rn}, 32'd0);
      check("t1_faddr", {18'h0, fa[0]}, 32'h40);
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      check("t2_waits", 32'(w), 32'd0);
      check("t2_data", d, 32'h11223344);
      check("t2_faddr", {18'h0, fa[0]}, 32'h40);

      // WS=3, prefetch, long idle
      apply_reset(1, 3, 1'b1);
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      check("t3_miss_waits", 32'(w), 32'd3);
      idle(5);
      check("t3_pf_faddr", {18'h0, fa[1]}, 32'h41);
      xfer(16'h0104, 1'b0, w, d, r1, rn);
      check("t3_waits", 32'(w), 32'd0);
      check("t3_data", d, 32'hC0DE0041);

      // WS=3, prefetch only partly aged
      apply_reset(1, 3, 1'b1);
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      idle(1);
      xfer(16'h0104, 1'b0, w, d, r1, rn);
      check("t4_waits", 32'(w), 32'd1);
      check("t4_data", d, 32'hC0DE0041);

      // write rejected, buffer preserved
      apply_reset(1, 3, 1'b1);
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      xfer(16'h0200, 1'b1, w, d, r1, rn);
      check("wr_waits", 32'(w), 32'd1);
      check("wr_resp1", {31'h0, r1}, 32'd1);
      check("wr_resp2", {31'h0, rn}, 32'd1);
      check("wr_faddr", {18'h0, fa[1]}, 32'h41);
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      check("wr_hit_waits", 32'(w), 32'd0);
      check("wr_hit_data", d, 32'h11223344);

      // top word, prefetch wraps to word 0
      xfer(16'hFFFC, 1'b0, w, d, r1, rn);
      check("top_waits", 32'(w), 32'd3);
      check("top_data", d, 32'hC0DE3FFF);
      idle(3);
      check("wrap_faddr", {18'h0, fa[1]}, 32'h0);
      xfer(16'h0000, 1'b0, w, d, r1, rn);
      check("wrap_waits", 32'(w), 32'd0);
      check("wrap_data", d, 32'hC0DE0000);

      // asynchronous reset during a wait state
      haddr = 16'h0800; hwrite = 1'b0; htrans = 2'b10;
      @(posedge clk); #1;
      htrans = 2'b00;
      check("mid_wait_low", {31'h0, hro[1]}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hreadyout", {31'h0, hro[1]}, 32'd1);
      check("arst_hresp", {31'h0, hrs[1]}, 32'd0);
      check("arst_hrdata", hrd[1], 32'h0);
      check("arst_faddr", {18'h0, fa[1]}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      xfer(16'h0100, 1'b0, w, d, r1, rn);
      check("post_rst_waits", 32'(w), 32'd3);
      check("post_rst_data", d, 32'h11223344);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
